// File: rtl/mem_requester.sv
// rtl/mem_requester.sv - byte-wise RAM request/ready initiator for 8/16-bit CPU accesses
// 16-bit accesses run as two little-endian byte phases, each guarded by a timeout watchdog.
module mem_requester #(
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cpu_start,
  input  logic                  i_cpu_we,
  input  logic                  i_cpu_wide,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic [15:0]           i_cpu_wdata,
  output logic                  o_cpu_busy,
  output logic                  o_cpu_done,
  output logic                  o_cpu_err,
  output logic [15:0]           o_cpu_rdata,
  output logic                  o_ram_req_rdwr,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [7:0]            o_ram_data_in,
  input  logic [7:0]            i_ram_data_out,
  input  logic                  i_ram_data_ready
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_LO,
    S_GAP,
    S_REQ_HI,
    S_DONE,
    S_ERR
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_wide;
  logic [7:0]      r_wdata_hi;
  logic [TW-1:0]   r_timer;
  logic            w_timeout;

  assign w_timeout = (r_timer == TW'(TIMEOUT - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (i_cpu_start) w_state_nxt = S_REQ_LO;
      S_REQ_LO: begin
        if (i_ram_data_ready) w_state_nxt = r_wide ? S_GAP : S_DONE;
        else if (w_timeout)   w_state_nxt = S_ERR;
      end
      S_GAP:    w_state_nxt = S_REQ_HI;
      S_REQ_HI: begin
        if (i_ram_data_ready) w_state_nxt = S_DONE;
        else if (w_timeout)   w_state_nxt = S_ERR;
      end
      S_DONE:   w_state_nxt = S_IDLE;
      S_ERR:    w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs are registered copies of the state being entered.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_cpu_busy     <= 1'b0;
      o_cpu_done     <= 1'b0;
      o_cpu_err      <= 1'b0;
      o_cpu_rdata    <= '0;
      o_ram_req_rdwr <= 1'b0;
      o_ram_we       <= 1'b0;
      o_ram_addr     <= '0;
      o_ram_data_in  <= '0;
      r_wide         <= 1'b0;
      r_wdata_hi     <= '0;
      r_timer        <= '0;
    end else begin
      o_cpu_busy     <= (w_state_nxt != S_IDLE);
      o_cpu_done     <= (w_state_nxt == S_DONE) || (w_state_nxt == S_ERR);
      o_cpu_err      <= (w_state_nxt == S_ERR);
      o_ram_req_rdwr <= (w_state_nxt == S_REQ_LO) || (w_state_nxt == S_REQ_HI);
      case (r_state)
        S_IDLE: begin
          if (i_cpu_start) begin
            o_ram_we      <= i_cpu_we;
            o_ram_addr    <= i_cpu_addr;
            o_ram_data_in <= i_cpu_wdata[7:0];
            r_wide        <= i_cpu_wide;
            r_wdata_hi    <= i_cpu_wdata[15:8];
            r_timer       <= '0;
          end
        end
        S_REQ_LO: begin
          r_timer <= r_timer + 1'b1;
          if (i_ram_data_ready && !o_ram_we) begin
            o_cpu_rdata[7:0] <= i_ram_data_out;
            if (!r_wide) o_cpu_rdata[15:8] <= 8'h00;
          end
        end
        S_GAP: begin
          o_ram_addr    <= o_ram_addr + 1'b1;
          o_ram_data_in <= r_wdata_hi;
          r_timer       <= '0;
        end
        S_REQ_HI: begin
          r_timer <= r_timer + 1'b1;
          if (i_ram_data_ready && !o_ram_we) o_cpu_rdata[15:8] <= i_ram_data_out;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_requester.sv
// tb/tb_mem_requester.sv - directed self-checking bench for mem_requester
module tb_mem_requester;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_start = 1'b0;
  logic        cpu_we = 1'b0;
  logic        cpu_wide = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_busy, cpu_done, cpu_err;
  logic [15:0] cpu_rdata;
  logic        ram_req_rdwr, ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_data_in;
  logic [7:0]  ram_data_out;
  logic        ram_data_ready;

  logic        ready_en = 1'b0;
  logic        ready_force = 1'b0;
  logic [7:0]  mem [0:65535];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cnt;

  always #5 clk = ~clk;

  mem_requester #(.ADDR_WIDTH(16), .TIMEOUT(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cpu_start(cpu_start), .i_cpu_we(cpu_we), .i_cpu_wide(cpu_wide),
    .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_busy(cpu_busy), .o_cpu_done(cpu_done), .o_cpu_err(cpu_err),
    .o_cpu_rdata(cpu_rdata),
    .o_ram_req_rdwr(ram_req_rdwr), .o_ram_we(ram_we),
    .o_ram_addr(ram_addr), .o_ram_data_in(ram_data_in),
    .i_ram_data_out(ram_data_out), .i_ram_data_ready(ram_data_ready)
  );

  // Zero-wait RAM responder: answers a live request in the same cycle when enabled.
  assign ram_data_ready = (ready_en & ram_req_rdwr) | ready_force;
  assign ram_data_out   = mem[ram_addr];

  always @(posedge clk)
    if (ram_req_rdwr && ram_we && ram_data_ready) mem[ram_addr] <= ram_data_in;

  logic [44:0] all_outs;
  assign all_outs = {cpu_busy, cpu_done, cpu_err, cpu_rdata, ram_req_rdwr, ram_we, ram_addr, ram_data_in};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_cmd(input logic we, input logic wide, input logic [15:0] addr, input logic [15:0] wdata);
    cpu_we = we; cpu_wide = wide; cpu_addr = addr; cpu_wdata = wdata; cpu_start = 1'b1;
    tick();
    cpu_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0010] = 8'hA5;
    mem[16'hFFFF] = 8'hCD;
    mem[16'h0000] = 8'hAB;

    tick(); tick();
    chk("reset_outputs", 64'(all_outs), 64'h0);
    rst = 1'b0;
    tick();
    chk("idle_after_reset", 64'(all_outs), 64'h0);

    // 8-bit read at 0x0010
    ready_en = 1'b1;
    start_cmd(1'b0, 1'b0, 16'h0010, 16'h0000);
    chk("rd8_req", 64'({ram_req_rdwr, ram_we, ram_addr, cpu_busy, cpu_done}), 64'({1'b1, 1'b0, 16'h0010, 1'b1, 1'b0}));
    tick();
    chk("rd8_done", 64'({cpu_done, cpu_err, ram_req_rdwr, cpu_busy, cpu_rdata}), 64'({1'b1, 1'b0, 1'b0, 1'b1, 16'h00A5}));
    tick();
    chk("rd8_idle", 64'({cpu_done, cpu_busy}), 64'h0);

    // 16-bit write 0x1234 at 0x0020
    start_cmd(1'b1, 1'b1, 16'h0020, 16'h1234);
    chk("wr16_ph1", 64'({ram_req_rdwr, ram_we, ram_addr, ram_data_in}), 64'({1'b1, 1'b1, 16'h0020, 8'h34}));
    tick();
    chk("wr16_gap", 64'({ram_req_rdwr, cpu_busy, cpu_done}), 64'({1'b0, 1'b1, 1'b0}));
    tick();
    chk("wr16_ph2", 64'({ram_req_rdwr, ram_we, ram_addr, ram_data_in}), 64'({1'b1, 1'b1, 16'h0021, 8'h12}));
    tick();
    chk("wr16_done", 64'({cpu_done, cpu_err, ram_req_rdwr, cpu_rdata}), 64'({1'b1, 1'b0, 1'b0, 16'h00A5}));
    tick();
    chk("wr16_mem", 64'({mem[16'h0021], mem[16'h0020]}), 64'h1234);

    // 16-bit read back
    start_cmd(1'b0, 1'b1, 16'h0020, 16'h0000);
    tick(); tick(); tick();
    chk("rd16_done", 64'({cpu_done, cpu_rdata}), 64'({1'b1, 16'h1234}));
    tick();

    // Address wrap at 0xFFFF
    start_cmd(1'b0, 1'b1, 16'hFFFF, 16'h0000);
    chk("wrap_ph1", 64'(ram_addr), 64'hFFFF);
    tick(); tick();
    chk("wrap_ph2", 64'({ram_req_rdwr, ram_addr}), 64'({1'b1, 16'h0000}));
    tick();
    chk("wrap_done", 64'({cpu_done, cpu_rdata}), 64'({1'b1, 16'hABCD}));
    tick();

    // Timeout in the low phase
    ready_en = 1'b0;
    start_cmd(1'b0, 1'b0, 16'h0030, 16'h0000);
    cnt = 0;
    for (int i = 0; i < 20 && ram_req_rdwr; i++) begin cnt++; tick(); end
    chk("to_lo_len", 64'(cnt), 64'd8);
    chk("to_lo_err", 64'({cpu_done, cpu_err, cpu_busy, cpu_rdata}), 64'({1'b1, 1'b1, 1'b1, 16'hABCD}));
    tick();
    chk("to_lo_after", 64'({cpu_done, cpu_err, cpu_busy}), 64'h0);

    // Timeout in the high phase after a good low byte
    ready_en = 1'b1;
    start_cmd(1'b0, 1'b1, 16'h0010, 16'h0000);
    tick();
    ready_en = 1'b0;
    tick();
    cnt = 0;
    for (int i = 0; i < 20 && ram_req_rdwr; i++) begin cnt++; tick(); end
    chk("to_hi_len", 64'(cnt), 64'd8);
    chk("to_hi_err", 64'({cpu_done, cpu_err, cpu_rdata}), 64'({1'b1, 1'b1, 16'hABA5}));
    tick();

    // Start held through REQ_LO and DONE must not launch a second access
    ready_en = 1'b1;
    cpu_we = 1'b0; cpu_wide = 1'b0; cpu_addr = 16'h0010; cpu_start = 1'b1;
    tick(); tick();
    chk("ign_done", 64'({cpu_done, cpu_rdata}), 64'({1'b1, 16'h00A5}));
    tick();
    cpu_start = 1'b0;
    chk("ign_start1", 64'({cpu_busy, ram_req_rdwr}), 64'h0);
    tick();
    chk("ign_start2", 64'({cpu_busy, ram_req_rdwr, cpu_done}), 64'h0);

    // Ready pulse while idle
    ready_force = 1'b1;
    tick();
    ready_force = 1'b0;
    tick();
    chk("ign_ready", 64'(all_outs), 64'({3'b000, 16'h00A5, 1'b0, 1'b0, 16'h0010, 8'h00}));

    // Reset during REQ_HI
    start_cmd(1'b0, 1'b1, 16'h0020, 16'h0000);
    tick();
    ready_en = 1'b0;
    tick();
    chk("rst_in_hi", 64'({ram_req_rdwr, ram_addr}), 64'({1'b1, 16'h0021}));
    #2 rst = 1'b1;
    #1 chk("rst_async", 64'(all_outs), 64'h0);
    tick();
    rst = 1'b0;
    ready_en = 1'b1;
    tick();
    start_cmd(1'b0, 1'b0, 16'h0010, 16'h0000);
    chk("post_rst_req", 64'({ram_req_rdwr, ram_addr}), 64'({1'b1, 16'h0010}));
    tick();
    chk("post_rst_done", 64'({cpu_done, cpu_err, cpu_rdata}), 64'({1'b1, 1'b0, 16'h00A5}));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
